// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RV32I multicycle controller: FSM states, opcodes,
// datapath select encodings, trap causes and instruction classes.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_e;

  // Base opcodes; the immediate generator keys its formats off the same values.
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_ALU    = 2'd2;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  localparam logic [1:0] ALU_OP_ADD    = 2'd0;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'd1;
  localparam logic [1:0] ALU_OP_PASS_B = 2'd2;

  localparam logic [1:0] TRAP_NONE          = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL       = 2'd1;
  localparam logic [1:0] TRAP_IMEM_TIMEOUT  = 2'd2;
  localparam logic [1:0] TRAP_DMEM_TIMEOUT  = 2'd3;

  typedef enum logic [3:0] {
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_OP_IMM,
    CLS_OP,
    CLS_LUI,
    CLS_AUIPC,
    CLS_JAL,
    CLS_JALR,
    CLS_ILLEGAL
  } iclass_e;

  function automatic iclass_e classify(input logic [6:0] opc);
    case (opc)
      OPC_LOAD:   return CLS_LOAD;
      OPC_STORE:  return CLS_STORE;
      OPC_BRANCH: return CLS_BRANCH;
      OPC_OP_IMM: return CLS_OP_IMM;
      OPC_OP:     return CLS_OP;
      OPC_LUI:    return CLS_LUI;
      OPC_AUIPC:  return CLS_AUIPC;
      OPC_JAL:    return CLS_JAL;
      OPC_JALR:   return CLS_JALR;
      default:    return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/rv_ctrl_wait_timer.sv
// Saturating wait counter for memory handshakes; expired flags the cycle in
// which an unacknowledged request reaches WAIT_MAX waiting cycles.
module rv_ctrl_wait_timer #(
  parameter int unsigned WAIT_MAX = 255,
  parameter int unsigned WAIT_W   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WAIT_W-1:0] MAX_V  = WAIT_W'(WAIT_MAX);
  localparam logic [WAIT_W-1:0] LAST_V = WAIT_W'(WAIT_MAX - 1);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts the waiting cycles already spent, so the current cycle is the last allowed one.
  assign expired = enable && (cnt_q >= LAST_V);

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multicycle RV32I control FSM sequencing fetch/decode/exec/mem/wb with req/ack
// memory handshakes and sticky traps. Define CTRL_PERF_CNT_EN for cycle/retire counters.
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 255,
  parameter int unsigned WAIT_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        retire,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] cyc_cnt,
  output logic [31:0] ret_cnt
);

  state_e     state_q, state_d;
  iclass_e    cls_q, cls_d;
  logic [1:0] cause_q, cause_d;

  logic       waiting, expired, tmr_clear;

  logic       imem_req_s, dmem_req_s, dmem_we_s, ir_we_s, pc_we_s;
  logic       alu_src_a_s, alu_src_b_s, rf_we_s, retire_s;
  logic [1:0] pc_src_s, alu_op_s, wb_sel_s;

  assign waiting   = ((state_q == ST_FETCH) && !imem_ack) ||
                     ((state_q == ST_MEM)   && !dmem_ack);
  assign tmr_clear = (state_d != state_q);

  rv_ctrl_wait_timer #(
    .WAIT_MAX (WAIT_MAX),
    .WAIT_W   (WAIT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmr_clear),
    .enable  (waiting),
    .expired (expired)
  );

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    cause_d     = cause_q;
    imem_req_s  = 1'b0;
    dmem_req_s  = 1'b0;
    dmem_we_s   = 1'b0;
    ir_we_s     = 1'b0;
    pc_we_s     = 1'b0;
    pc_src_s    = PC_SRC_PLUS4;
    alu_src_a_s = 1'b0;
    alu_src_b_s = 1'b0;
    alu_op_s    = ALU_OP_ADD;
    rf_we_s     = 1'b0;
    wb_sel_s    = WB_SEL_ALU;
    retire_s    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        imem_req_s = 1'b1;
        if (imem_ack) begin
          ir_we_s = 1'b1;
          state_d = ST_DECODE;
        end else if (expired) begin
          state_d = ST_TRAP;
          cause_d = TRAP_IMEM_TIMEOUT;
        end
      end

      ST_DECODE: begin
        cls_d = classify(opcode);
        if (cls_d == CLS_ILLEGAL) begin
          state_d = ST_TRAP;
          cause_d = TRAP_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        case (cls_q)
          CLS_BRANCH: begin
            alu_op_s = ALU_OP_FUNCT;
            pc_we_s  = 1'b1;
            pc_src_s = branch_taken ? PC_SRC_BRANCH : PC_SRC_PLUS4;
            retire_s = 1'b1;
            state_d  = ST_FETCH;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_src_b_s = 1'b1;
            state_d     = ST_MEM;
          end
          CLS_OP_IMM: begin
            alu_src_b_s = 1'b1;
            alu_op_s    = ALU_OP_FUNCT;
            state_d     = ST_WB;
          end
          CLS_OP: begin
            alu_op_s = ALU_OP_FUNCT;
            state_d  = ST_WB;
          end
          CLS_LUI: begin
            alu_src_b_s = 1'b1;
            alu_op_s    = ALU_OP_PASS_B;
            state_d     = ST_WB;
          end
          CLS_AUIPC, CLS_JAL: begin
            alu_src_a_s = 1'b1;
            alu_src_b_s = 1'b1;
            state_d     = ST_WB;
          end
          CLS_JALR: begin
            alu_src_b_s = 1'b1;
            state_d     = ST_WB;
          end
          default: state_d = ST_FETCH;
        endcase
      end

      ST_MEM: begin
        dmem_req_s = 1'b1;
        dmem_we_s  = (cls_q == CLS_STORE);
        if (dmem_ack) begin
          if (cls_q == CLS_STORE) begin
            pc_we_s  = 1'b1;
            retire_s = 1'b1;
            state_d  = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (expired) begin
          state_d = ST_TRAP;
          cause_d = TRAP_DMEM_TIMEOUT;
        end
      end

      ST_WB: begin
        rf_we_s  = 1'b1;
        pc_we_s  = 1'b1;
        retire_s = 1'b1;
        state_d  = ST_FETCH;
        if (cls_q == CLS_LOAD) begin
          wb_sel_s = WB_SEL_MEM;
        end else if ((cls_q == CLS_JAL) || (cls_q == CLS_JALR)) begin
          wb_sel_s = WB_SEL_PC4;
        end
        if (cls_q == CLS_JAL) begin
          pc_src_s = PC_SRC_BRANCH;
        end else if (cls_q == CLS_JALR) begin
          pc_src_s = PC_SRC_ALU;
        end
      end

      ST_TRAP: state_d = ST_TRAP;

      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      cls_q   <= CLS_ILLEGAL;
      cause_q <= TRAP_NONE;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cause_q <= cause_d;
    end
  end

  // Gating with rst_n drops any in-flight request the moment reset asserts.
  assign imem_req   = imem_req_s  & rst_n;
  assign dmem_req   = dmem_req_s  & rst_n;
  assign dmem_we    = dmem_we_s   & rst_n;
  assign ir_we      = ir_we_s     & rst_n;
  assign pc_we      = pc_we_s     & rst_n;
  assign alu_src_a  = alu_src_a_s & rst_n;
  assign alu_src_b  = alu_src_b_s & rst_n;
  assign rf_we      = rf_we_s     & rst_n;
  assign retire     = retire_s    & rst_n;
  assign pc_src     = rst_n ? pc_src_s : 2'd0;
  assign alu_op     = rst_n ? alu_op_s : 2'd0;
  assign wb_sel     = rst_n ? wb_sel_s : 2'd0;
  assign trap       = (state_q == ST_TRAP);
  assign trap_cause = cause_q;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cyc_q, ret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (state_q != ST_TRAP) begin
        cyc_q <= cyc_q + 32'd1;
      end
      if (retire_s) begin
        ret_q <= ret_q + 32'd1;
      end
    end
  end

  assign cyc_cnt = cyc_q;
  assign ret_cnt = ret_q;
`else
  assign cyc_cnt = '0;
  assign ret_cnt = '0;
`endif

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Self-checking bench for rv_multicycle_ctrl: an instruction-level model predicts every
// cycle's strobes under randomized acks/opcodes; directed runs pin latencies and traps.
module tb_rv_multicycle_ctrl;

  localparam int WMAX = 4;

  localparam int C_ILL = 0, C_LOAD = 1, C_STORE = 2, C_BR = 3, C_JAL = 4, C_JALR = 5, C_ALU = 6;

  localparam logic [6:0] T_LOAD = 7'b0000011, T_OPIMM = 7'b0010011, T_STORE = 7'b0100011,
                         T_BR = 7'b1100011, T_LUI = 7'b0110111, T_AUIPC = 7'b0010111,
                         T_JAL = 7'b1101111, T_JALR = 7'b1100111, T_OP = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [6:0]  opcode = 7'd0;
  logic        branch_taken = 1'b0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, alu_src_a, alu_src_b;
  logic        rf_we, retire, trap;
  logic [1:0]  pc_src, alu_op, wb_sel, trap_cause;
  logic [31:0] cyc_cnt, ret_cnt;

  rv_multicycle_ctrl #(.WAIT_MAX(WMAX), .WAIT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .rf_we(rf_we),
    .wb_sel(wb_sel), .retire(retire), .trap(trap), .trap_cause(trap_cause),
    .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       imemReq, dmemReq, dmemWe, irWe, pcWe, rfWe, retire, trap, chkAlu;
    logic [1:0] pcSrc, wbSel, cause;
  } expT;

  expT         e;
  logic        trapped = 1'b0;
  logic [1:0]  causeM = 2'd0;
  logic [31:0] cycM = 32'd0, retM = 32'd0;
  int          checks = 0, errors = 0;
  int          relCyc = 0, firstRet = 0, firstTrap = 0;

  function automatic int classOf(input logic [6:0] o);
    case (o)
      T_LOAD:  return C_LOAD;
      T_STORE: return C_STORE;
      T_BR:    return C_BR;
      T_JAL:   return C_JAL;
      T_JALR:  return C_JALR;
      T_OPIMM, T_OP, T_LUI, T_AUIPC: return C_ALU;
      default: return C_ILL;
    endcase
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic expT idle();
    expT x;
    x = '0;
    x.trap  = trapped;
    x.cause = causeM;
    return x;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison against the expectation published for the current cycle.
  always @(negedge clk) begin
    checkOutput("imem_req", 32'(imem_req), 32'(e.imemReq));
    checkOutput("dmem_req", 32'(dmem_req), 32'(e.dmemReq));
    checkOutput("ir_we", 32'(ir_we), 32'(e.irWe));
    checkOutput("pc_we", 32'(pc_we), 32'(e.pcWe));
    checkOutput("rf_we", 32'(rf_we), 32'(e.rfWe));
    checkOutput("retire", 32'(retire), 32'(e.retire));
    checkOutput("trap", 32'(trap), 32'(e.trap));
    checkOutput("trap_cause", 32'(trap_cause), 32'(e.cause));
    if (e.dmemReq) checkOutput("dmem_we", 32'(dmem_we), 32'(e.dmemWe));
    if (e.pcWe) checkOutput("pc_src", 32'(pc_src), 32'(e.pcSrc));
    if (e.rfWe) checkOutput("wb_sel", 32'(wb_sel), 32'(e.wbSel));
    if (e.chkAlu) checkOutput("alu_op_addr", 32'(alu_op), 32'd0);
`ifdef CTRL_PERF_CNT_EN
    checkOutput("cyc_cnt", cyc_cnt, cycM);
    checkOutput("ret_cnt", ret_cnt, retM);
`else
    checkOutput("cyc_cnt_tied", cyc_cnt, 32'd0);
    checkOutput("ret_cnt_tied", ret_cnt, 32'd0);
`endif
    if (!rst_n) begin
      cycM = 0; retM = 0; relCyc = 0; firstRet = 0; firstTrap = 0;
    end else begin
      if (!e.trap) cycM = cycM + 32'd1;
      if (e.retire) retM = retM + 32'd1;
      relCyc++;
      if (retire && firstRet == 0) firstRet = relCyc;
      if (trap && firstTrap == 0) firstTrap = relCyc;
    end
  end

  task automatic applyStimulus(input logic ia, input logic da, input logic bt);
    imem_ack = ia;
    dmem_ack = da;
    branch_taken = bt;
    @(posedge clk);
    #1;
  endtask

  task automatic enterTrap(input logic [1:0] c);
    trapped = 1'b1;
    causeM  = c;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    trapped = 1'b0;
    causeM = 2'd0;
    e = idle();
    applyStimulus(1'b1, 1'b1, rbit());
    applyStimulus(1'b1, 1'b1, rbit());
    rst_n = 1'b1;
  endtask

  task automatic runTrapped(input int n);
    for (int k = 0; k < n; k++) begin
      e = idle();
      applyStimulus(rbit(), rbit(), rbit());
    end
  endtask

  // One instruction: iDel/dDel are the no-ack cycles before each memory acknowledges.
  task automatic runInstr(input logic [6:0] opc, input int iDel, input int dDel, input logic taken);
    int cls;
    int j;
    cls = classOf(opc);
    opcode = opc;
    j = 0;
    while (1) begin
      e = idle();
      e.imemReq = 1'b1;
      if (j >= iDel) begin
        e.irWe = 1'b1;
        applyStimulus(1'b1, rbit(), rbit());
        break;
      end
      applyStimulus(1'b0, rbit(), rbit());
      if (j == WMAX - 1) begin enterTrap(2'd2); return; end
      j++;
    end
    e = idle();
    applyStimulus(rbit(), rbit(), rbit());
    if (cls == C_ILL) begin enterTrap(2'd1); return; end
    e = idle();
    if (cls == C_BR) begin
      e.pcWe = 1'b1; e.retire = 1'b1; e.pcSrc = {1'b0, taken};
      applyStimulus(rbit(), rbit(), taken);
      return;
    end
    e.chkAlu = (cls == C_LOAD) || (cls == C_STORE);
    applyStimulus(rbit(), rbit(), rbit());
    if (cls == C_LOAD || cls == C_STORE) begin
      j = 0;
      while (1) begin
        e = idle();
        e.dmemReq = 1'b1;
        e.dmemWe  = (cls == C_STORE);
        if (j >= dDel) begin
          if (cls == C_STORE) begin e.pcWe = 1'b1; e.retire = 1'b1; e.pcSrc = 2'd0; end
          applyStimulus(rbit(), 1'b1, rbit());
          break;
        end
        applyStimulus(rbit(), 1'b0, rbit());
        if (j == WMAX - 1) begin enterTrap(2'd3); return; end
        j++;
      end
      if (cls == C_STORE) return;
    end
    e = idle();
    e.rfWe = 1'b1; e.pcWe = 1'b1; e.retire = 1'b1;
    e.wbSel = (cls == C_LOAD) ? 2'd1 : ((cls == C_JAL || cls == C_JALR) ? 2'd2 : 2'd0);
    e.pcSrc = (cls == C_JAL) ? 2'd1 : ((cls == C_JALR) ? 2'd2 : 2'd0);
    applyStimulus(rbit(), rbit(), rbit());
  endtask

  logic [6:0] legal [9];
  logic [6:0] opc;
  int         iD, dD;

  initial begin
    legal = '{T_LOAD, T_OPIMM, T_STORE, T_BR, T_LUI, T_AUIPC, T_JAL, T_JALR, T_OP};
    e = idle();
    #1 rst_n = 1'b0;
    @(posedge clk); #1;

    // Zero-wait addi retires in cycle 4.
    applyReset();
    runInstr(T_OPIMM, 0, 0, 1'b0);
    checkOutput("addi_retire_cycle", 32'(firstRet), 32'd4);

    // Load with a 3-cycle data wait retires in cycle 8.
    applyReset();
    runInstr(T_LOAD, 0, 3, 1'b0);
    checkOutput("load_retire_cycle", 32'(firstRet), 32'd8);

    runInstr(T_BR, 0, 0, 1'b1);
    runInstr(T_BR, 0, 0, 1'b0);
    runInstr(T_JALR, 0, 0, 1'b0);
    runInstr(T_JAL, 1, 0, 1'b0);
    runInstr(T_STORE, 2, 2, 1'b0);

    // Illegal opcode traps after decode and only reset clears it.
    applyReset();
    runInstr(7'h7F, 0, 0, 1'b0);
    runTrapped(3);
    checkOutput("illegal_trap", 32'(trap), 32'd1);
    checkOutput("illegal_cause", 32'(trap_cause), 32'd1);
    applyReset();
    checkOutput("trap_cleared", 32'(trap), 32'd0);

    // Fetch timeout: trap visible in cycle 5 with cause 2.
    applyReset();
    runInstr(T_OPIMM, WMAX, 0, 1'b0);
    runTrapped(2);
    checkOutput("imem_timeout_cycle", 32'(firstTrap), 32'd5);
    checkOutput("imem_timeout_cause", 32'(trap_cause), 32'd2);

    // Ack on the final allowed cycle wins.
    applyReset();
    runInstr(T_OPIMM, WMAX - 1, 0, 1'b0);
    checkOutput("ack_wins_retire", 32'(firstRet), 32'd7);
    checkOutput("ack_wins_no_trap", 32'(firstTrap), 32'd0);

    // Data timeout.
    runInstr(T_STORE, 0, WMAX, 1'b0);
    runTrapped(2);
    checkOutput("dmem_timeout_cause", 32'(trap_cause), 32'd3);

    // Reset in the middle of a fetch wait, then a full-length wait must still succeed.
    applyReset();
    e = idle(); e.imemReq = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyReset();
    runInstr(T_LUI, WMAX - 1, 0, 1'b0);

    // Ten back-to-back addi.
    applyReset();
    for (int k = 0; k < 10; k++) runInstr(T_OPIMM, 0, 0, 1'b0);
`ifdef CTRL_PERF_CNT_EN
    checkOutput("perf_ret_10", ret_cnt, 32'd10);
    checkOutput("perf_cyc_40", cyc_cnt, 32'd40);
`else
    checkOutput("perf_ret_off", ret_cnt, 32'd0);
    checkOutput("perf_cyc_off", cyc_cnt, 32'd0);
`endif

    // Randomized instruction stream.
    applyReset();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        do opc = 7'($urandom); while (classOf(opc) != C_ILL);
      end else begin
        opc = legal[$urandom_range(0, 8)];
      end
      iD = ($urandom_range(0, 15) == 0) ? WMAX : $urandom_range(0, WMAX - 1);
      dD = ($urandom_range(0, 15) == 0) ? WMAX : $urandom_range(0, WMAX - 1);
      runInstr(opc, iD, dD, rbit());
      if (trapped) begin
        runTrapped(3);
        applyReset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
